// File: rtl/keccak_sipo_pad_pkg.sv
// keccak_pkg: shared constants and FSM state type for the Keccak absorb buffer.
// Defining KECCAK_SIPO_PAD_EN turns on pad10*1 insertion (PAD_EN).
package keccak_pkg;
  localparam int RATE_BITS = 1344;
  localparam int RATE_BYTES = RATE_BITS / 8;
  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST = 8'h80;
`ifdef KECCAK_SIPO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  typedef enum logic {FILL, OUT} state_t;
endpackage

// File: rtl/keccak_pad_byte.sv
// keccak_pad_byte: per-word byte-valid mask and in-word 0x01 pad vector for the final word.
module keccak_pad_byte import keccak_pkg::*; #(
  parameter int DATA_W = 64,
  localparam int NB = DATA_W / 8,
  localparam int BW = $clog2(NB) + 1
) (
  input  logic [BW-1:0]     i_bytes,
  input  logic              i_last,
  output logic [DATA_W-1:0] o_mask,
  output logic [DATA_W-1:0] o_pad,
  output logic              o_full
);
  logic [BW-1:0] w_nb;
  assign w_nb = (i_bytes > BW'(NB)) ? BW'(NB) : i_bytes;
  assign o_full = i_last && (w_nb == BW'(NB));
  for (genvar j = 0; j < NB; j++) begin : g_byte
    assign o_mask[DATA_W-1-8*j -: 8] = {8{!i_last || (BW'(j) < w_nb)}};
    assign o_pad[DATA_W-1-8*j -: 8] = (PAD_EN && i_last && w_nb == BW'(j)) ? PAD_FIRST : 8'h00;
  end
endmodule

// File: rtl/keccak_sipo_pad.sv
// keccak_sipo_pad: serial-in/parallel-out rate-block absorb buffer, MSB-first words.
// Pad10*1 and the extra pad-only block are enabled by KECCAK_SIPO_PAD_EN.
module keccak_sipo_pad import keccak_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int RATE = RATE_BITS,
  localparam int NB = DATA_W / 8,
  localparam int BW = $clog2(NB) + 1,
  localparam int W = RATE / DATA_W,
  localparam int CW = $clog2(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [BW-1:0]     in_bytes,
  output logic              in_ready,
  output logic [RATE-1:0]   block_out,
  output logic              block_valid,
  output logic              block_last,
  input  logic              block_ready
);
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [RATE-1:0] r_buf, w_buf, w_ins;
  logic r_last, w_last, r_pend, w_pend;
  logic [DATA_W-1:0] w_mask, w_pad;
  logic w_full, w_end, w_spill, w_pad_end;

  keccak_pad_byte #(.DATA_W(DATA_W)) u_pad (
    .i_bytes(in_bytes),
    .i_last (in_last),
    .o_mask (w_mask),
    .o_pad  (w_pad),
    .o_full (w_full)
  );

  assign w_end = r_cnt == CW'(W - 1);
  assign w_spill = PAD_EN && in_last && w_full && w_end;
  assign w_pad_end = PAD_EN && in_last && !w_spill;
  // A full final word before the block end pushes its 0x01 into byte 0 of the next word.
  assign w_ins = {(in_data & w_mask) | w_pad,
                  (PAD_EN && w_full && !w_end) ? PAD_FIRST : 8'h00,
                  {(RATE-DATA_W-8){1'b0}}} >> (int'(r_cnt) * DATA_W);

  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_buf = r_buf;
    w_last = r_last;
    w_pend = r_pend;
    if (r_state == FILL && in_valid) begin
      w_buf = r_buf | w_ins | (w_pad_end ? RATE'(PAD_LAST) : '0);
      w_cnt = (in_last || w_end) ? r_cnt : r_cnt + 1'b1;
      w_state = (in_last || w_end) ? OUT : FILL;
      w_pend = w_spill;
      w_last = in_last && !w_spill;
    end else if (r_state == OUT && block_ready) begin
      w_state = r_pend ? OUT : FILL;
      w_cnt = '0;
      w_buf = r_pend ? {PAD_FIRST, {(RATE-16){1'b0}}, PAD_LAST} : '0;
      w_last = r_pend;
      w_pend = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_cnt <= '0;
      r_buf <= '0;
      r_last <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_buf <= w_buf;
      r_last <= w_last;
      r_pend <= w_pend;
    end
  end

  assign in_ready = r_state == FILL;
  assign block_valid = r_state == OUT;
  assign block_last = r_last;
  assign block_out = r_buf;
endmodule

// File: tb/tb_keccak_sipo_pad.sv
// tb_keccak_sipo_pad: randomized bench for keccak_sipo_pad against a byte-level pad10*1 model.
module tb_keccak_sipo_pad;
  localparam int DW = 64;
  localparam int RATE = 1344;
  localparam int BY = 168;
`ifdef KECCAK_SIPO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic block_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [3:0] in_bytes = '0;
  logic in_ready, block_valid, block_last;
  logic [RATE-1:0] block_out;
  int tests_run = 0;
  int tests_failed = 0;
  logic [RATE-1:0] got_blk[$];
  logic got_last[$];

  always #5 clk = ~clk;

  keccak_sipo_pad dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(in_ready), .block_out(block_out),
    .block_valid(block_valid), .block_last(block_last), .block_ready(block_ready)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // mode: 0 = block_ready low, 1 = high, 2 = random
  task automatic tick(input int mode, output bit acc);
    block_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    @(negedge clk);
    acc = in_valid && in_ready;
    if (block_valid && block_ready) begin
      got_blk.push_back(block_out);
      got_last.push_back(block_last);
    end
    if (block_valid) begin
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL in_ready_in_out: got %b want 0", in_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input bit last, input logic [3:0] nb,
                           input int mode, input int idle);
    bit acc;
    int guard;
    in_valid = 1'b0;
    repeat (idle) tick(mode, acc);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    in_bytes = nb;
    guard = 0;
    do begin
      tick(mode, acc);
      guard++;
    end while (!acc && guard < 200);
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL word_accept: got timeout want accept");
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic run_msg(input string name, input int nw, input bit has_last, input int nb,
                         input bit seq, input int mode);
    logic [7:0] eb[];
    logic [63:0] d;
    logic [RATE-1:0] ex;
    int nbc, p, len, nblk, guard, bad;
    bit lw, acc;
    got_blk.delete();
    got_last.delete();
    nbc = nb > 8 ? 8 : nb;
    p = (nw - 1) * 8 + nbc;
    len = nw * 8;
    if (has_last && PAD && p + 1 > len) len = p + 1;
    len = ((len + BY - 1) / BY) * BY;
    eb = new[len];
    foreach (eb[i]) eb[i] = 8'h00;
    for (int w = 0; w < nw; w++) begin
      d = seq ? 64'(w + 1) : {$urandom, $urandom};
      lw = has_last && w == nw - 1;
      for (int j = 0; j < 8; j++)
        if (!lw || j < nbc) eb[w*8+j] = d[63-8*j -: 8];
      send_word(d, lw, lw ? 4'(nb) : 4'($urandom_range(0, 15)), mode,
                mode == 2 ? $urandom_range(0, 2) : 0);
    end
    if (has_last && PAD) begin
      eb[p] |= 8'h01;
      eb[len-1] |= 8'h80;
    end
    nblk = len / BY;
    guard = 0;
    while (got_blk.size() < nblk && guard < 300) begin
      tick(mode == 0 ? 1 : mode, acc);
      guard++;
    end
    repeat (3) tick(1, acc);
    tests_run++;
    if (got_blk.size() != nblk) begin
      tests_failed++;
      $display("FAIL %s block_count: got %0d want %0d", name, got_blk.size(), nblk);
    end
    for (int b = 0; b < nblk && b < got_blk.size(); b++) begin
      for (int i = 0; i < BY; i++) ex[RATE-1-8*i -: 8] = eb[b*BY+i];
      tests_run++;
      if (got_blk[b] !== ex) begin
        bad = 0;
        for (int i = BY - 1; i >= 0; i--) if (got_blk[b][RATE-1-8*i -: 8] !== ex[RATE-1-8*i -: 8]) bad = i;
        tests_failed++;
        $display("FAIL %s block%0d data: byte %0d got %h want %h", name, b, bad,
                 got_blk[b][RATE-1-8*bad -: 8], ex[RATE-1-8*bad -: 8]);
      end
      tests_run++;
      if (got_last[b] !== (has_last && b == nblk - 1)) begin
        tests_failed++;
        $display("FAIL %s block%0d last: got %b want %b", name, b, got_last[b], has_last && b == nblk - 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run += 4;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    if (block_valid !== 1'b0) begin tests_failed++; $display("FAIL reset block_valid: got %b want 0", block_valid); end
    if (block_last !== 1'b0) begin tests_failed++; $display("FAIL reset block_last: got %b want 0", block_last); end
    if (block_out !== '0) begin tests_failed++; $display("FAIL reset block_out: got nonzero want 0"); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_block();
    logic [RATE-1:0] b;
    run_msg("full", 21, 1'b0, 0, 1'b1, 1);
    b = got_blk.size() > 0 ? got_blk[0] : '0;
    tests_run += 2;
    if (b[1343 -: 64] !== 64'h1) begin tests_failed++; $display("FAIL full word0: got %h want 1", b[1343 -: 64]); end
    if (b[63:0] !== 64'h15) begin tests_failed++; $display("FAIL full word20: got %h want 15", b[63:0]); end
  endtask

  task automatic test_empty();
    logic [RATE-1:0] b;
    run_msg("empty", 1, 1'b1, 0, 1'b0, 1);
    b = got_blk.size() > 0 ? got_blk[0] : {RATE{1'b1}};
    tests_run += 2;
    if (b[RATE-1 -: 8] !== (PAD ? 8'h01 : 8'h00)) begin tests_failed++; $display("FAIL empty byte0: got %h want %h", b[RATE-1 -: 8], PAD ? 8'h01 : 8'h00); end
    if (b[7:0] !== (PAD ? 8'h80 : 8'h00)) begin tests_failed++; $display("FAIL empty byte167: got %h want %h", b[7:0], PAD ? 8'h80 : 8'h00); end
  endtask

  task automatic test_pad_fit();
    logic [RATE-1:0] b;
    run_msg("fit", 21, 1'b1, 7, 1'b0, 1);
    b = got_blk.size() > 0 ? got_blk[0] : '1;
    tests_run++;
    if (b[7:0] !== (PAD ? 8'h81 : 8'h00)) begin tests_failed++; $display("FAIL fit byte167: got %h want %h", b[7:0], PAD ? 8'h81 : 8'h00); end
  endtask

  task automatic test_pend_pad();
    run_msg("pend", 21, 1'b1, 8, 1'b0, 1);
    run_msg("pend_next", 22, 1'b1, 0, 1'b0, 1);
  endtask

  task automatic test_backpressure();
    logic [RATE-1:0] ex;
    bit acc;
    int guard;
    got_blk.delete();
    got_last.delete();
    for (int w = 0; w < 21; w++) begin
      send_word(64'(w + 'h100), 1'b0, 4'd0, 0, 0);
      ex[RATE-1-64*w -: 64] = 64'(w + 'h100);
    end
    in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    for (int c = 0; c < 10; c++) begin
      tick(0, acc);
      tests_run += 3;
      if (acc !== 1'b0) begin tests_failed++; $display("FAIL bp accept cyc%0d: got %b want 0", c, acc); end
      if (block_valid !== 1'b1) begin tests_failed++; $display("FAIL bp valid cyc%0d: got %b want 1", c, block_valid); end
      if (block_out !== ex) begin tests_failed++; $display("FAIL bp stable cyc%0d: got %h want %h", c, block_out[RATE-1 -: 64], ex[RATE-1 -: 64]); end
    end
    in_valid = 1'b0;
    guard = 0;
    while (got_blk.size() < 1 && guard < 20) begin tick(1, acc); guard++; end
    tests_run++;
    if (got_blk.size() < 1 || got_blk[0] !== ex) begin tests_failed++; $display("FAIL bp block: got count %0d want matching block", got_blk.size()); end
    run_msg("after_bp", 21, 1'b0, 0, 1'b1, 1);
  endtask

  task automatic test_rst_mid();
    for (int w = 0; w < 5; w++) send_word({$urandom, $urandom}, 1'b0, 4'd0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run += 2;
    if (block_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_fill valid: got %b want 0", block_valid); end
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_fill ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_msg("post_rst", 21, 1'b0, 0, 1'b1, 1);
    for (int w = 0; w < 21; w++) send_word({$urandom, $urandom}, w == 20, 4'd8, 0, 0);
    tests_run++;
    if (block_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_out pre valid: got %b want 1", block_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run += 2;
    if (block_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out valid: got %b want 0", block_valid); end
    if (block_out !== '0) begin tests_failed++; $display("FAIL rst_out data: got nonzero want 0"); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_msg("post_rst_out", 1, 1'b1, 3, 1'b0, 1);
  endtask

  task automatic test_random();
    for (int m = 0; m < 25; m++)
      run_msg($sformatf("rand%0d", m), $urandom_range(1, 45), 1'b1, $urandom_range(0, 15), 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_empty();
    test_pad_fit();
    test_pend_pad();
    test_backpressure();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
